// File: rtl/oled_spi_tx.sv
// oled_spi_tx
//   Byte-level SPI transmitter for the SSD1306 OLED (4-wire, write-only,
//   mode 0, MSB first). It answers the spi_send / spi_data / send_done
//   handshake of the OLED sequencers. It latches one byte and its D/C flag,
//   shifts the byte out, and then pulses send_done for one cycle.
//
//   Optional feature: define OLED_SPI_BURST_EN to keep cs_n low for up to
//   BURST_WIN cycles after a frame. A following byte with the same D/C value
//   then skips the chip-select setup phase.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   spi_send   in   level request, held by the initiator until send_done
//   spi_data   in   byte to send
//   dc_in      in   0 = command byte, 1 = display data byte
//   send_done  out  one-cycle pulse when the byte has been fully sent
//   busy       out  high from acceptance until the cycle after send_done
//   oled_sclk  out  SPI clock, idle low
//   oled_sdin  out  SPI data; changes on SCLK fall
//   oled_cs_n  out  chip select, active low
//   oled_dc    out  D/C pin; registered at acceptance, stable for the frame
module oled_spi_tx #(
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int BURST_WIN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_send,
  input  logic [7:0] spi_data,
  input  logic       dc_in,
  output logic       send_done,
  output logic       busy,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_cs_n,
  output logic       oled_dc
);

  // One shared down-counter times setup, half-periods, hold and the burst window.
  localparam int CNT_MAX_A = (CLK_DIV  > CS_SETUP)  ? CLK_DIV  : CS_SETUP;
  localparam int CNT_MAX_B = (CS_HOLD  > BURST_WIN) ? CS_HOLD  : BURST_WIN;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
`ifdef OLED_SPI_BURST_EN
  localparam logic [CNT_W-1:0] WIN_LD   = CNT_W'(BURST_WIN - 1);
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, ARMED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             accept;
  logic             shift_fall;

  // accept: a new byte is latched this cycle.
  // shift_fall: SCLK falls and the next lower bit is presented.
  always_comb begin
    accept = (state == IDLE) && spi_send;
`ifdef OLED_SPI_BURST_EN
    if ((state == ARMED) && spi_send && (dc_in == oled_dc)) accept = 1'b1;
`endif
    shift_fall = (state == SHIFT) && (cnt == '0) && oled_sclk && (bit_cnt != 3'd0);
  end

  // Byte shift register; data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept)          shreg <= spi_data;
    else if (shift_fall) shreg <= {shreg[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      send_done <= 1'b0;
      busy      <= 1'b0;
      oled_sclk <= 1'b0;
      oled_sdin <= 1'b0;
      oled_cs_n <= 1'b1;
      oled_dc   <= 1'b0;
    end else begin
      send_done <= 1'b0;
      case (state)
        IDLE: begin
          if (spi_send) begin
            state     <= SETUP;
            cnt       <= SETUP_LD;
            oled_cs_n <= 1'b0;
            oled_dc   <= dc_in;
            oled_sdin <= spi_data[7];
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state   <= SHIFT;
            cnt     <= DIV_LD;
            bit_cnt <= 3'd7;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!oled_sclk) begin
            oled_sclk <= 1'b1;
            cnt       <= DIV_LD;
          end else begin
            oled_sclk <= 1'b0;
            if (bit_cnt == 3'd0) begin
              state <= HOLD;
              cnt   <= HOLD_LD;
            end else begin
              bit_cnt   <= bit_cnt - 1'b1;
              oled_sdin <= shreg[6];
              cnt       <= DIV_LD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state     <= DONE;
            send_done <= 1'b1;
`ifndef OLED_SPI_BURST_EN
            oled_cs_n <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          oled_sdin <= 1'b0;
`ifdef OLED_SPI_BURST_EN
          state     <= ARMED;
          cnt       <= WIN_LD;
`else
          state     <= IDLE;
`endif
        end
`ifdef OLED_SPI_BURST_EN
        // cs_n is still low here. A same-D/C byte starts shifting at once.
        // A D/C change or window expiry releases cs_n.
        ARMED: begin
          if (spi_send) begin
            if (dc_in == oled_dc) begin
              state     <= SHIFT;
              cnt       <= DIV_LD;
              bit_cnt   <= 3'd7;
              oled_sdin <= spi_data[7];
              busy      <= 1'b1;
            end else begin
              oled_cs_n <= 1'b1;
              state     <= IDLE;
            end
          end else if (cnt == '0) begin
            oled_cs_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
